uart_rx: RTL and testbench
==========================

# uart_rx

- UART receiver: the receiving end of the team's UART serial link.
- Deserialises an 8N1 frame (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) from the asynchronous `Rx` line.
- Presents each good byte with a one-cycle `byte_ready` strobe and flags bad stop bits with `framing_err`.
- Sits beside the transmitter at the serial pins; bit timing comes from a parameterised clocks-per-bit divider.

## Interface
- `CLKS_PER_BIT`, 10416: system clocks per bit period (100 MHz / 9600 baud). Legal values: even, ≥ 4.
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `Rx` input 1: serial line, asynchronous to `clk`, idle high.
- `data` output 8: last correctly received byte; holds until the next good byte.
- `byte_ready` output 1: one-cycle pulse when `data` has just been updated.
- `framing_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `busy` output 1: high in every state except IDLE.

## Operation
- `Rx` passes through a 2-flop synchroniser; both flops reset to 1. All logic uses the synchronised value `rx_s`.
- Counter `cnt`, width `$clog2(CLKS_PER_BIT)`:
  - Clears on every state entry and increments every clock.
  - Also clears when a DATA bit is sampled.
- Bit index `idx`, 3 bits: clears on entry to DATA.
- States:
  - **IDLE**: `rx_s == 0` → START.
  - **START**: at `cnt == CLKS_PER_BIT/2-1`, sample `rx_s`. Sample 1 → IDLE (glitch rejected, no pulse). Sample 0 → DATA.
  - **DATA**: at `cnt == CLKS_PER_BIT-1`, shift `rx_s` into the MSB of an 8-bit shift register, shifting right so bits land LSB first. `idx` increments. After the sample with `idx == 7` → STOP.
  - **STOP**: at `cnt == CLKS_PER_BIT-1`, sample `rx_s`.
    - Sample 1: `data` ← shift register, `byte_ready` = 1 for the next cycle, → IDLE.
    - Sample 0: `framing_err` = 1 for the next cycle, `data` unchanged, → RECOVER.
  - **RECOVER**: wait for `rx_s == 1`, then → IDLE. This keeps a break condition from being read as a stream of start bits.
- `byte_ready` and `framing_err` are registered, never both high, and each lasts exactly one cycle.
- No overrun handling: a byte not consumed is overwritten by the next good byte.

## Timing
- Reset values: `data` = 8'h00, `byte_ready` = 0, `framing_err` = 0, `busy` = 0, state = IDLE, `cnt` = 0, `idx` = 0.
- Reset mid-frame (`reset` low at any point): immediate return to IDLE, partial byte discarded, no pulse.
- Synchroniser latency: a `Rx` fall set up before clock edge E is visible in `rx_s` after edge E+1; START is entered at edge E+2.
- Sample points, counted from START entry:
  - Start bit: CLKS_PER_BIT/2 clocks.
  - Data bit k: CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT clocks.
  - Stop bit: CLKS_PER_BIT/2 + 9·CLKS_PER_BIT clocks.
- `byte_ready` / `framing_err` go high on the edge after the stop sample.
- Total latency from the `Rx` falling edge to the strobe: 9.5·CLKS_PER_BIT + 3 clocks, ±1.
- Back-to-back frames: IDLE is reached with half a bit period to spare before the next start edge, so a next start bit arriving at the nominal time is never missed.
- `busy` asserts the cycle after IDLE exits and deasserts on the IDLE entry edge.

## Structure
- Shared package `uart_pkg`:
  - `rx_state_t` enum: IDLE, START, DATA, STOP, RECOVER.
  - `UART_DATA_BITS` = 8, shared with the transmitter.
- One sub-module, `rx_bit_timer`: owns `cnt` and produces the `half_tick` / `full_tick` strobes from `CLKS_PER_BIT`. It is the receive-side counterpart of the transmitter's baud counter.
- Synchroniser, FSM and shift register live in `uart_rx` itself.

## Test plan
All scenarios use `CLKS_PER_BIT = 8`.

1. **Reset values**: assert `reset` low for 3 clocks with `Rx` = 1 → all outputs zero, `busy` = 0.
2. **Good frame**: send 8'hA5 8N1 → one `byte_ready` pulse 79±1 clocks after the start edge, `data` = 8'hA5, `framing_err` never high.
3. **Back-to-back frames**: send 8'h00 then 8'hFF with no idle gap → two `byte_ready` pulses 80 clocks apart, `data` = 8'h00 then 8'hFF.
4. **Start glitch**: drive `Rx` low for 2 clocks only → START then IDLE, no pulse, `busy` high for at most 4 clocks.
5. **Framing error and break**: send 8'h3C with the stop bit low and hold `Rx` low for 40 more clocks →
   - `framing_err` pulses once;
   - `data` keeps its previous value;
   - state stays in RECOVER until `Rx` rises;
   - a following 8'h5A frame is received correctly.
6. **Reset mid-frame**: pull `reset` low during data bit 4 of 8'h81 → immediate IDLE, no pulse; the next frame 8'h7E is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive paths.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    RECOVER = 3'd4
  } rx_state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// Receive-side baud counter: free-running count with a synchronous clear,
// flagging the mid-bit and end-of-bit clocks.
module rx_bit_timer #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic half_tick_o,
  output logic full_tick_o
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear on request, otherwise count up.
  always_comb begin
    if (clr_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign half_tick_o = (cnt_q == HALF_LAST);
  assign full_tick_o = (cnt_q == FULL_LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchroniser, bit-sampling FSM and shift register,
// with one-cycle byte_ready / framing_err strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      byte_ready,
  output logic                      framing_err,
  output logic                      busy
);

  localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

  logic                      sync1_q;
  logic                      rx_s;
  rx_state_t                 state_q;
  rx_state_t                 state_d;
  logic [2:0]                idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] data_q;
  logic                      byte_ready_q;
  logic                      framing_err_q;
  logic                      busy_q;
  logic                      half_tick_s;
  logic                      full_tick_s;
  logic                      data_sample_s;
  logic                      clr_s;

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= Rx;
      rx_s    <= sync1_q;
    end
  end

  // Next state; the bit counter restarts on every state change and per data bit.
  always_comb begin
    state_d       = state_q;
    data_sample_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
        else       state_d = IDLE;
      end
      START: begin
        if (half_tick_s) state_d = rx_s ? IDLE : DATA;
        else             state_d = START;
      end
      DATA: begin
        if (full_tick_s) begin
          data_sample_s = 1'b1;
          state_d       = (idx_q == LAST_IDX) ? STOP : DATA;
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (full_tick_s) state_d = rx_s ? IDLE : RECOVER;
        else             state_d = STOP;
      end
      RECOVER: begin
        // A held-low line (break) must go high before a new start is accepted.
        if (rx_s) state_d = IDLE;
        else      state_d = RECOVER;
      end
      default: state_d = IDLE;
    endcase
    clr_s = (state_d != state_q) || data_sample_s;
  end

  rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (clr_s),
    .half_tick_o(half_tick_s),
    .full_tick_o(full_tick_s)
  );

  // FSM state, bit index, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      idx_q         <= 3'd0;
      shift_q       <= '0;
      data_q        <= '0;
      byte_ready_q  <= 1'b0;
      framing_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= (state_d != IDLE);
      byte_ready_q  <= (state_q == STOP) && full_tick_s && rx_s;
      framing_err_q <= (state_q == STOP) && full_tick_s && !rx_s;
      if ((state_q == STOP) && full_tick_s && rx_s) begin
        data_q <= shift_q;
      end
      if (data_sample_s) begin
        shift_q <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
        idx_q   <= idx_q + 3'd1;
      end else if ((state_d == DATA) && (state_q != DATA)) begin
        idx_q <= 3'd0;
      end
    end
  end

  assign data        = data_q;
  assign byte_ready  = byte_ready_q;
  assign framing_err = framing_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 8 clocks per bit: frame table plus
// hand-written glitch, break and mid-frame reset sequences.
module tb_uart_rx;

  localparam int CPB = 8;

  typedef struct {
    logic [7:0] d;
    int         start;
    bit         b2b;
  } sb_t;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         gap;
    logic [7:0] exp_data;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       byte_ready;
  logic       framing_err;
  logic       busy;

  int  checks;
  int  errors;
  int  cyc;
  int  br_seen;
  int  fe_seen;
  int  exp_fe;
  int  last_br;
  sb_t sb_q[$];
  vec_t vecs[8];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .Rx         (rx),
    .data       (data),
    .byte_ready (byte_ready),
    .framing_err(framing_err),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: scoreboard pop on byte_ready, pulse-shape checks.
  initial begin
    sb_t e;
    logic br_prev;
    logic fe_prev;
    int lat;
    br_prev = 1'b0;
    fe_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (byte_ready) begin
          checks = checks + 1;
          if (sb_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_byte_ready: got data %0h expected no strobe", data);
          end else begin
            e = sb_q.pop_front();
            lat = cyc - e.start;
            if (data !== e.d || lat < 78 || lat > 80) begin
              errors = errors + 1;
              $display("FAIL rx_byte: got %0h latency %0d expected %0h latency 78..80", data, lat, e.d);
            end
            if (e.b2b) begin
              checks = checks + 1;
              if (cyc - last_br != 80) begin
                errors = errors + 1;
                $display("FAIL b2b_spacing: got %0d expected 80", cyc - last_br);
              end
            end
          end
          last_br = cyc;
          br_seen = br_seen + 1;
        end
        if (framing_err) fe_seen = fe_seen + 1;
        if (byte_ready || framing_err) begin
          checks = checks + 1;
          if ((byte_ready && framing_err) || (byte_ready && br_prev) || (framing_err && fe_prev)) begin
            errors = errors + 1;
            $display("FAIL strobe_shape: got br=%0b fe=%0b prev br=%0b fe=%0b expected single exclusive pulse",
                     byte_ready, framing_err, br_prev, fe_prev);
          end
        end
      end
      br_prev = byte_ready;
      fe_prev = framing_err;
    end
  end

  // Drive one 8N1 frame starting now (just after a clock edge); Rx ends at the stop value.
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = stop_bit;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit b2b);
    sb_t e;
    if (stop_bit) begin
      e.d = b;
      e.start = cyc;
      e.b2b = b2b;
      sb_q.push_back(e);
    end else begin
      exp_fe = exp_fe + 1;
    end
    drive_frame(b, stop_bit);
  endtask

  initial begin
    int busy_cnt;
    int br_before;
    int waited;
    checks  = 0;
    errors  = 0;
    br_seen = 0;
    fe_seen = 0;
    exp_fe  = 0;
    last_br = 0;

    vecs[0] = '{8'hA5, 1'b1, 4, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 4, 8'hFF};
    vecs[3] = '{8'hC3, 1'b0, 4, 8'hFF};
    vecs[4] = '{8'h81, 1'b1, 3, 8'h81};
    vecs[5] = '{8'h01, 1'b1, 0, 8'h01};
    vecs[6] = '{8'h80, 1'b1, 5, 8'h80};
    vecs[7] = '{8'h7E, 1'b1, 2, 8'h7E};

    // Reset values
    rx = 1'b1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_data", data, 8'h00);
    chk("reset_byte_ready", byte_ready, 1'b0);
    chk("reset_framing_err", framing_err, 1'b0);
    chk("reset_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Frame table: good, back-to-back and bad-stop frames
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].d, vecs[i].stop, (i > 0) && (vecs[i-1].gap == 0));
      rx = 1'b1;
      if (vecs[i].gap > 0) begin
        @(negedge clk);
        chk("table_data", data, vecs[i].exp_data);
        if (vecs[i].stop) chk("table_busy_idle", busy, 1'b0);
        repeat (vecs[i].gap) @(posedge clk);
        #1;
      end
    end
    chk("table_fe_count", fe_seen, exp_fe);

    // Start glitch: two clocks low
    br_before = br_seen;
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_cnt = busy_cnt + 1;
    end
    chk("glitch_busy_seen", (busy_cnt >= 1) && (busy_cnt <= 4), 1'b1);
    chk("glitch_no_byte", br_seen, br_before);
    @(posedge clk);
    #1;

    // Framing error followed by a 40-clock break
    send_frame(8'h3C, 1'b0, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) busy_cnt = busy_cnt + 1;
    end
    chk("break_stays_busy", busy_cnt, 0);
    chk("break_fe_once", fe_seen, exp_fe);
    chk("break_data_kept", data, 8'h7E);
    @(posedge clk);
    #1;
    rx = 1'b1;
    waited = 0;
    while (busy !== 1'b0 && waited < 10) begin
      @(negedge clk);
      waited = waited + 1;
    end
    chk("break_recover_idle", busy, 1'b0);
    @(posedge clk);
    #1;
    send_frame(8'h5A, 1'b1, 1'b0);
    @(negedge clk);
    chk("after_break_data", data, 8'h5A);
    @(posedge clk);
    #1;

    // Reset during data bit 4
    br_before = br_seen;
    fork
      drive_frame(8'h81, 1'b1);
      begin
        repeat (44) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_data", data, 8'h00);
      end
    join
    rx = 1'b1;
    chk("midreset_no_byte", br_seen, br_before);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midreset_idle", busy, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b0);
    @(negedge clk);
    chk("after_reset_data", data, 8'h7E);
    repeat (4) @(posedge clk);
    #1;

    chk("sb_drained", sb_q.size(), 0);
    chk("fe_total", fe_seen, exp_fe);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
